seg_timer_display: RTL and testbench
====================================

// Module: seg_timer_display
// PURPOSE
//  Consumer of the game-control match timer: converts the 8-bit remaining-seconds count
//  (0..255) to BCD with a sequential double-dabble engine and drives the 4-digit
//  multiplexed seven-segment display. Sits between the game top level and the board
//  an/seven pins.
// PARAMETERS
//  SCAN_CYCLES   100000    clk cycles each digit slot stays active (1 ms at 100 MHz)
//  BLINK_CYCLES  25000000  clk cycles per blink half-period (SEG_BLINK_EN only)
// PORTS
//  clk     in   1   system clock, all logic on posedge
//  rst_n   in   1   reset, asynchronous, active-low
//  num     in   8   remaining time in seconds, unsigned
//  paused  in   1   game paused (port exists only with SEG_BLINK_EN)
//  bcd     out  12  {hundreds,tens,ones} of last completed conversion
//  busy    out  1   conversion in progress
//  an      out  4   digit enables, active-low, an[0] = ones (rightmost)
//  seven   out  8   segments {dp,g,f,e,d,c,b,a}, active-low, dp always 1
// BEHAVIOUR
//  Reset (async assert, sync-safe release): an=4'b1111, seven=8'hFF, bcd=0, busy=0,
//   scan counter=0, digit index=0, pending=1 (forces a conversion right after reset).
//  Converter FSM IDLE -> SHIFT -> DONE -> IDLE:
//   IDLE: if pending or num != last_num: capture num into shadow and last_num,
//    clear pending, clear work BCD, busy=1, go SHIFT.
//   SHIFT: 8 cycles, one bit each; add 3 to any BCD nibble >= 5, then shift left
//    by 1 with the next shadow MSB entering. Width: 12-bit work reg + 8-bit shadow.
//   DONE: bcd <= work, busy=0, go IDLE.
//  Latency: num change sampled in IDLE -> bcd updated 10 clk later (1+8+1).
//  num changing during SHIFT/DONE is ignored until IDLE; the last value is then
//   converted (intermediate values may be skipped; no glitched bcd ever output).
//  Display always uses registered bcd; it holds the old value during conversion.
//  Scan: counter 0..SCAN_CYCLES-1, wraps to 0 and advances digit index 0->1->2->3->0.
//   idx0: an=1110, ones; idx1: an=1101, tens; idx2: an=1011, hundreds;
//   idx3: an=1111, seven=FF (blank slot, keeps 1/4 duty).
//  Leading-zero blanking: hundreds blank if 0; tens blank if hundreds==0 and tens==0;
//   ones always shown (0 shows "0"). A blanked digit drives its an low, seven=FF.
//  Codes 0..9: C0 F9 A4 B0 99 92 82 F8 80 90; nibble >9 cannot occur, decode to FF.
//  an and seven are registered, change together on the same edge.
//  Reset mid-conversion aborts FSM to IDLE with pending=1; bcd returns to 0.
// CONFIGURATION
//  SEG_BLINK_EN defined: port paused exists; free-running blink counter 0..BLINK_CYCLES-1
//   toggles phase; while paused=1 and phase=1, an=1111 and seven=FF in every slot;
//   paused=0 shows normally immediately; phase resets to 0 on reset. Converter
//   unaffected.
//  SEG_BLINK_EN undefined: no paused port, no blink counter, display never blanks.
// TESTING
//  1 rst_n=0 with num=180 -> an=1111, seven=FF, bcd=0; release -> busy=1 then bcd=12'h180
//    after 10 clk, busy=0.
//  2 num=180 steady, SCAN_CYCLES=4 -> an sequence 1110/F9? no: ones 0=C0, tens 8=80,
//    hundreds 1=F9, then 1111/FF, repeating every 16 clk.
//  3 num=7 -> bcd=12'h007; idx0 seven=F8; idx1 and idx2 seven=FF; num=0 -> idx0 shows C0.
//  4 num=255 then 254 on 3rd SHIFT cycle -> bcd=12'h255 first, then 12'h254 after busy
//    reasserts; no other bcd value observed.
//  5 rst_n pulsed low during SHIFT -> outputs at reset values asynchronously; new
//    conversion of current num completes 10 clk after release.
//  6 SEG_BLINK_EN, BLINK_CYCLES=8, paused=1 -> all digits dark 8 clk, shown 8 clk,
//    alternating; paused=0 -> display steady.

Source files
------------

// File: rtl/seg_timer_display.sv
// seg_timer_display
//   Converts the 8-bit remaining-seconds count (0..255) to BCD with a sequential
//   double-dabble engine and drives a 4-digit multiplexed seven-segment display.
//
// Parameters
//   SCAN_CYCLES   clk cycles each digit slot stays active
//   BLINK_CYCLES  clk cycles per blink half-period (only with SEG_BLINK_EN)
//
// Ports
//   clk     in   1   system clock, posedge
//   rst_n   in   1   asynchronous active-low reset
//   num     in   8   remaining time in seconds, unsigned
//   paused  in   1   game paused (only with SEG_BLINK_EN)
//   bcd     out  12  {hundreds,tens,ones} of the last completed conversion
//   busy    out  1   conversion in progress
//   an      out  4   digit enables, active-low, an[0] = ones (rightmost)
//   seven   out  8   segments {dp,g,f,e,d,c,b,a}, active-low, dp always 1
//
// Configuration
//   SEG_BLINK_EN  when defined, adds the paused port and a blink counter that
//                 darkens the whole display every other half-period while paused.

`timescale 1ns/1ps

module seg_timer_display #(
    parameter int unsigned SCAN_CYCLES  = 100000
`ifdef SEG_BLINK_EN
    ,
    parameter int unsigned BLINK_CYCLES = 25000000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  num,
`ifdef SEG_BLINK_EN
    input  logic        paused,
`endif
    output logic [11:0] bcd,
    output logic        busy,
    output logic [3:0]  an,
    output logic [7:0]  seven
);

    localparam int unsigned ScanW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } conv_state_e;

    // Active-low segment pattern for one BCD digit.
    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // ------------------------------------------------------------------
    // Converter
    // ------------------------------------------------------------------
    conv_state_e state_q, state_d;
    logic        pending_q, pending_d;
    logic [7:0]  last_num_q, last_num_d;
    logic [7:0]  shadow_q, shadow_d;
    logic [11:0] work_q, work_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [11:0] bcd_q, bcd_d;
    logic        busy_q, busy_d;
    logic [11:0] work_adj;

    always_comb begin
        work_adj = {add3(work_q[11:8]), add3(work_q[7:4]), add3(work_q[3:0])};

        state_d    = state_q;
        pending_d  = pending_q;
        last_num_d = last_num_q;
        shadow_d   = shadow_q;
        work_d     = work_q;
        bit_cnt_d  = bit_cnt_q;
        bcd_d      = bcd_q;
        busy_d     = busy_q;

        case (state_q)
            StIdle: begin
                if (pending_q || (num != last_num_q)) begin
                    shadow_d   = num;
                    last_num_d = num;
                    pending_d  = 1'b0;
                    work_d     = '0;
                    bit_cnt_d  = '0;
                    busy_d     = 1'b1;
                    state_d    = StShift;
                end
            end
            StShift: begin
                // Hundreds never exceeds 2 for an 8-bit input, so bit 11 is always 0.
                work_d    = {work_adj[10:0], shadow_q[7]};
                shadow_d  = {shadow_q[6:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                bcd_d   = work_q;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pending_q  <= 1'b1;
            last_num_q <= '0;
            shadow_q   <= '0;
            work_q     <= '0;
            bit_cnt_q  <= '0;
            bcd_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            last_num_q <= last_num_d;
            shadow_q   <= shadow_d;
            work_q     <= work_d;
            bit_cnt_q  <= bit_cnt_d;
            bcd_q      <= bcd_d;
            busy_q     <= busy_d;
        end
    end

    assign bcd  = bcd_q;
    assign busy = busy_q;

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]       digit_idx_q, digit_idx_d;
    logic [3:0]       an_q, an_d;
    logic [7:0]       seven_q, seven_d;
    logic             scan_wrap;
    logic             hund_blank, tens_blank;

`ifdef SEG_BLINK_EN
    localparam int unsigned BlinkW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_phase_q, blink_phase_d;
    logic              blink_wrap;

    always_comb begin
        blink_wrap    = (blink_cnt_q == BlinkW'(BLINK_CYCLES - 1));
        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end
`endif

    always_comb begin
        scan_wrap   = (scan_cnt_q == ScanW'(SCAN_CYCLES - 1));
        scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        digit_idx_d = scan_wrap ? digit_idx_q + 2'd1 : digit_idx_q;

        // Leading-zero blanking; ones is always shown.
        hund_blank = (bcd_q[11:8] == 4'd0);
        tens_blank = hund_blank && (bcd_q[7:4] == 4'd0);

        unique case (digit_idx_q)
            2'd0: begin
                an_d    = 4'b1110;
                seven_d = seg_code(bcd_q[3:0]);
            end
            2'd1: begin
                an_d    = 4'b1101;
                seven_d = tens_blank ? 8'hFF : seg_code(bcd_q[7:4]);
            end
            2'd2: begin
                an_d    = 4'b1011;
                seven_d = hund_blank ? 8'hFF : seg_code(bcd_q[11:8]);
            end
            default: begin
                // Blank fourth slot keeps each digit at 1/4 duty.
                an_d    = 4'b1111;
                seven_d = 8'hFF;
            end
        endcase

`ifdef SEG_BLINK_EN
        if (paused && blink_phase_q) begin
            an_d    = 4'b1111;
            seven_d = 8'hFF;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q  <= '0;
            digit_idx_q <= '0;
            an_q        <= 4'b1111;
            seven_q     <= 8'hFF;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
            an_q        <= an_d;
            seven_q     <= seven_d;
        end
    end

    assign an    = an_q;
    assign seven = seven_q;

endmodule

// File: tb/tb_seg_timer_display.sv
`timescale 1ns/1ps

module tb_seg_timer_display;

    localparam int unsigned SCAN  = 4;
    localparam int unsigned BLINK = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  num = 8'd180;
    logic [11:0] bcd;
    logic        busy;
    logic [3:0]  an;
    logic [7:0]  seven;
`ifdef SEG_BLINK_EN
    logic        paused = 1'b0;
`endif

    always #5 clk = ~clk;

    seg_timer_display #(
        .SCAN_CYCLES  (SCAN)
`ifdef SEG_BLINK_EN
        ,
        .BLINK_CYCLES (BLINK)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .num   (num),
`ifdef SEG_BLINK_EN
        .paused(paused),
`endif
        .bcd   (bcd),
        .busy  (busy),
        .an    (an),
        .seven (seven)
    );

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];
    logic [11:0] prev_bcd = 12'h000;
    int unsigned ec;

    // Clock edges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ec <= 0;
        else        ec <= ec + 1;
    end

    // Every distinct bcd value the DUT presents goes to the observed queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_bcd = 12'h000;
        end else if (bcd !== prev_bcd) begin
            obs_q.push_back(bcd);
            prev_bcd = bcd;
        end
    end

    function automatic logic [11:0] bcd_model(input logic [7:0] n);
        int v;
        v = int'(n);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] code(input int d);
        logic [7:0] tbl [10];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return tbl[d];
    endfunction

    // Expected {an, seven} for slot idx while value n is displayed.
    function automatic logic [11:0] frame_model(input logic [7:0] n, input int idx);
        int v;
        v = int'(n);
        case (idx)
            0:       return {4'b1110, code(v % 10)};
            1:       return {4'b1101, (v < 10)  ? 8'hFF : code((v / 10) % 10)};
            2:       return {4'b1011, (v < 100) ? 8'hFF : code(v / 100)};
            default: return {4'b1111, 8'hFF};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // Counts edges until a conversion that starts on the next edge finishes.
    task automatic wait_conv(output int cyc);
        bit done;
        cyc  = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) chk("busy_rise", {31'd0, busy}, 32'd1);
            if (cyc > 1 && !busy) done = 1'b1;
        end
    endtask

    task automatic sb_pop(input string tag);
        chk({tag, "_avail"}, {31'd0, (obs_q.size() != 0 && exp_q.size() != 0)}, 32'd1);
        if (obs_q.size() != 0 && exp_q.size() != 0)
            chk(tag, {20'd0, obs_q.pop_front()}, {20'd0, exp_q.pop_front()});
    endtask

    task automatic convert(input logic [7:0] n);
        int cyc;
        @(negedge clk);
        num = n;
        exp_q.push_back(bcd_model(n));
        wait_conv(cyc);
        chk("conv_latency", cyc, 32'd10);
        @(negedge clk);
        #1;
        sb_pop("conv_bcd");
    endtask

    // Aligns to the start of slot 0 and checks one full 16-cycle frame.
    task automatic frame_check(input logic [7:0] n);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an == 4'b1111) found = 1'b1;
        end
        if (found) begin
            found = 1'b0;
            for (int i = 0; i < 10 && !found; i++) begin
                @(negedge clk);
                if (an != 4'b1111) found = 1'b1;
            end
        end
        chk("scan_align", {31'd0, found}, 32'd1);
        if (found) begin
            for (int i = 0; i < 16; i++) begin
                chk("scan", {20'd0, an, seven}, {20'd0, frame_model(n, i / 4)});
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int cyc;

        // 1: reset state and first conversion
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_an", {28'd0, an}, 32'h0000000F);
        chk("rst_seven", {24'd0, seven}, 32'h000000FF);
        chk("rst_bcd", {20'd0, bcd}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        exp_q.push_back(bcd_model(8'd180));
        wait_conv(cyc);
        chk("rst_latency", cyc, 32'd10);
        @(negedge clk);
        #1;
        sb_pop("rst_bcd180");
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // 2: scan sequence for 180
        frame_check(8'd180);

        // 3: leading-zero blanking
        convert(8'd7);
        frame_check(8'd7);
        convert(8'd0);
        frame_check(8'd0);

        // 4: input change mid-conversion is deferred, never glitches bcd
        @(negedge clk);
        num = 8'd255;
        exp_q.push_back(bcd_model(8'd255));
        repeat (3) @(posedge clk);
        @(negedge clk);
        num = 8'd254;
        exp_q.push_back(bcd_model(8'd254));
        repeat (40) @(negedge clk);
        chk("defer_count", obs_q.size(), 32'd2);
        sb_pop("defer_first");
        sb_pop("defer_second");
        chk("defer_extra", obs_q.size(), 32'd0);

        // 5: reset in the middle of a conversion
        @(negedge clk);
        num = 8'd99;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_an", {28'd0, an}, 32'h0000000F);
        chk("abort_seven", {24'd0, seven}, 32'h000000FF);
        chk("abort_bcd", {20'd0, bcd}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        obs_q.delete();
        rst_n = 1'b1;
        exp_q.push_back(bcd_model(8'd99));
        wait_conv(cyc);
        chk("abort_latency", cyc, 32'd10);
        @(negedge clk);
        #1;
        sb_pop("abort_bcd99");
        frame_check(8'd99);

`ifdef SEG_BLINK_EN
        // 6: blink while paused, steady once resumed
        @(negedge clk);
        paused = 1'b1;
        for (int i = 0; i < 32; i++) begin
            int k;
            @(negedge clk);
            k = int'(ec);
            if (((k - 1) / int'(BLINK)) % 2 == 1)
                chk("blink_dark", {20'd0, an, seven}, 32'h00000FFF);
            else
                chk("blink_lit", {20'd0, an, seven},
                    {20'd0, frame_model(8'd99, ((k - 1) / int'(SCAN)) % 4)});
        end
        paused = 1'b0;
        for (int i = 0; i < 16; i++) begin
            int k;
            @(negedge clk);
            k = int'(ec);
            chk("resume", {20'd0, an, seven},
                {20'd0, frame_model(8'd99, ((k - 1) / int'(SCAN)) % 4)});
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
